// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter
//   Shares one SPI flash between the 6809 read controller (CPU) and the FT2232
//   flash writer (HOST). When ownership changes, the flash is held deselected
//   for GAP_CYCLES clocks. While the CPU wants the flash but does not own it,
//   its bus cycle is stretched through o_MRDY.
//
// Ports
//   clk              system clock, the only clock
//   reset            asynchronous reset, active low
//   i_cpu_req        6809 flash-window request (clk domain)
//   i_cpu_spi_*      SPI clk/mosi/cs from the read controller
//   i_cpu_ready      read controller data-valid
//   i_FT_CS          FT2232 programming select, active low, asynchronous
//   i_host_spi_*     SPI clk/mosi/cs from the FT2232 writer
//   o_SPI_*          SPI pins to the flash
//   o_cpu_grant      read controller owns the flash
//   o_host_grant     FT2232 owns the flash
//   o_MRDY           memory-ready to the 6809 (0 = stretch)
//   o_status         [1:0] state, [2] host_pending, [3] cpu_pending,
//                    [7:4] host_sessions (saturating)
//
// Request/grant semantics: a request is a level. A requester keeps its
// request asserted until the corresponding grant is seen. It then keeps the
// request asserted for as long as it needs the flash. Ownership is released
// only through GAP. An owner is never preempted.
module spi_flash_arbiter #(
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_cpu_req,
  input  logic       i_cpu_spi_clk,
  input  logic       i_cpu_spi_mosi,
  input  logic       i_cpu_spi_cs,
  input  logic       i_cpu_ready,
  input  logic       i_FT_CS,
  input  logic       i_host_spi_clk,
  input  logic       i_host_spi_mosi,
  input  logic       i_host_spi_cs,
  output logic       o_SPI_CLK,
  output logic       o_SPI_MOSI,
  output logic       o_SPI_CS,
  output logic       o_cpu_grant,
  output logic       o_host_grant,
  output logic       o_MRDY,
  output logic [7:0] o_status
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_HOST = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_gap_cnt;
  logic       r_host_pending;
  logic       r_cpu_pending;
  logic [3:0] r_host_sessions;
  logic       r_ft_cs_meta;
  logic       r_ft_cs_sync;
  logic       w_host_req;

  // i_FT_CS comes from the FT2232 with no relation to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ft_cs_meta <= 1'b1;
      r_ft_cs_sync <= 1'b1;
    end else begin
      r_ft_cs_meta <= i_FT_CS;
      r_ft_cs_sync <= r_ft_cs_meta;
    end
  end

  assign w_host_req = ~r_ft_cs_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_gap_cnt       <= 4'd0;
      r_host_pending  <= 1'b0;
      r_cpu_pending   <= 1'b0;
      r_host_sessions <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The host wins a tie: a programming session must not be starved
          // by a CPU that reads continuously.
          if (w_host_req) begin
            r_state        <= ST_HOST;
            r_host_pending <= 1'b0;
            if (r_host_sessions != 4'hF) begin
              r_host_sessions <= r_host_sessions + 4'd1;
            end
          end else if (i_cpu_req) begin
            r_state       <= ST_CPU;
            r_cpu_pending <= 1'b0;
          end
        end
        ST_CPU: begin
          if (w_host_req) begin
            r_host_pending <= 1'b1;
          end
          // Wait for the read controller to deselect the flash as well, so
          // that an SPI transaction is never cut in half.
          if (!i_cpu_req && i_cpu_spi_cs) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= GAP_LOAD;
          end
        end
        ST_HOST: begin
          if (i_cpu_req) begin
            r_cpu_pending <= 1'b1;
          end
          if (!w_host_req) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The mux depends only on the registered state. An asynchronous reset
  // therefore deselects the flash immediately.
  always_comb begin
    o_SPI_CLK  = 1'b0;
    o_SPI_MOSI = 1'b0;
    o_SPI_CS   = 1'b1;
    o_MRDY     = ~i_cpu_req;
    case (r_state)
      ST_CPU: begin
        o_SPI_CLK  = i_cpu_spi_clk;
        o_SPI_MOSI = i_cpu_spi_mosi;
        o_SPI_CS   = i_cpu_spi_cs;
        o_MRDY     = i_cpu_ready;
      end
      ST_HOST: begin
        o_SPI_CLK  = i_host_spi_clk;
        o_SPI_MOSI = i_host_spi_mosi;
        o_SPI_CS   = i_host_spi_cs;
      end
      default: begin
      end
    endcase
  end

  assign o_cpu_grant  = (r_state == ST_CPU);
  assign o_host_grant = (r_state == ST_HOST);
  assign o_status     = {r_host_sessions, r_cpu_pending, r_host_pending, r_state};

endmodule

// File: tb/tb_spi_flash_arbiter.sv
module tb_spi_flash_arbiter;

  logic       clk;
  logic       reset;
  logic       i_cpu_req;
  logic       i_cpu_spi_clk;
  logic       i_cpu_spi_mosi;
  logic       i_cpu_spi_cs;
  logic       i_cpu_ready;
  logic       i_FT_CS;
  logic       i_host_spi_clk;
  logic       i_host_spi_mosi;
  logic       i_host_spi_cs;
  logic       o_SPI_CLK;
  logic       o_SPI_MOSI;
  logic       o_SPI_CS;
  logic       o_cpu_grant;
  logic       o_host_grant;
  logic       o_MRDY;
  logic [7:0] o_status;

  spi_flash_arbiter #(.GAP_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_cpu_req       (i_cpu_req),
    .i_cpu_spi_clk   (i_cpu_spi_clk),
    .i_cpu_spi_mosi  (i_cpu_spi_mosi),
    .i_cpu_spi_cs    (i_cpu_spi_cs),
    .i_cpu_ready     (i_cpu_ready),
    .i_FT_CS         (i_FT_CS),
    .i_host_spi_clk  (i_host_spi_clk),
    .i_host_spi_mosi (i_host_spi_mosi),
    .i_host_spi_cs   (i_host_spi_cs),
    .o_SPI_CLK       (o_SPI_CLK),
    .o_SPI_MOSI      (o_SPI_MOSI),
    .o_SPI_CS        (o_SPI_CS),
    .o_cpu_grant     (o_cpu_grant),
    .o_host_grant    (o_host_grant),
    .o_MRDY          (o_MRDY),
    .o_status        (o_status)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: {cpu_grant, host_grant, spi_clk, spi_mosi, spi_cs, mrdy, status}
  localparam int W = 14;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp;
  int           n_fail;

  typedef struct {
    logic [4:0]   cpu_in;  // {req, spi_clk, spi_mosi, spi_cs, ready}
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [W-1:0] pk(logic cg, logic hg, logic c, logic m, logic s,
                                      logic r, logic [7:0] st);
    return {cg, hg, c, m, s, r, st};
  endfunction

  // Scoreboard
  task automatic push_exp(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check_pop();
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    a  = {o_cpu_grant, o_host_grant, o_SPI_CLK, o_SPI_MOSI, o_SPI_CS, o_MRDY, o_status};
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got cg=%b hg=%b clk=%b mosi=%b cs=%b mrdy=%b status=%02h, expected cg=%b hg=%b clk=%b mosi=%b cs=%b mrdy=%b status=%02h",
               nm, a[13], a[12], a[11], a[10], a[9], a[8], a[7:0],
               e[13], e[12], e[11], e[10], e[9], e[8], e[7:0]);
    end
  endtask

  // Drivers
  task automatic drive(input logic req, input logic c, input logic m, input logic s,
                       input logic rdy, input logic ft, input logic hc, input logic hm,
                       input logic hs);
    i_cpu_req       = req;
    i_cpu_spi_clk   = c;
    i_cpu_spi_mosi  = m;
    i_cpu_spi_cs    = s;
    i_cpu_ready     = rdy;
    i_FT_CS         = ft;
    i_host_spi_clk  = hc;
    i_host_spi_mosi = hm;
    i_host_spi_cs   = hs;
  endtask

  // One clock: move 2 ns past the rising edge, drive the inputs, expect the
  // outputs for this cycle, and sample 1 ns later.
  task automatic step(input string nm, input logic req, input logic c, input logic m,
                      input logic s, input logic rdy, input logic ft, input logic hc,
                      input logic hm, input logic hs, input logic [W-1:0] e);
    @(posedge clk);
    #2;
    drive(req, c, m, s, rdy, ft, hc, hm, hs);
    push_exp(nm, e);
    #1;
    check_pop();
  endtask

  task automatic idle_cycles(input int n, input logic ft);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ft, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    // CPU read with GAP_CYCLES=4. The host SPI inputs are held active and
    // must never show on the flash pins.
    //                 req c m s rdy           cg hg c  m  s  mrdy status
    tbl[0]  = '{5'b11100, pk(0, 0, 0, 0, 1, 0, 8'h00)};  // IDLE, req seen
    tbl[1]  = '{5'b10100, pk(1, 0, 0, 1, 0, 0, 8'h01)};  // grant one cycle later
    tbl[2]  = '{5'b11001, pk(1, 0, 1, 0, 0, 1, 8'h01)};  // MRDY follows ready
    tbl[3]  = '{5'b00001, pk(1, 0, 0, 0, 0, 1, 8'h01)};  // req low, cs low: hold
    tbl[4]  = '{5'b10010, pk(1, 0, 0, 0, 1, 0, 8'h01)};  // cs high, req high: hold
    tbl[5]  = '{5'b00010, pk(1, 0, 0, 0, 1, 0, 8'h01)};  // release
    tbl[6]  = '{5'b01101, pk(0, 0, 0, 0, 1, 1, 8'h03)};  // GAP 1
    tbl[7]  = '{5'b01101, pk(0, 0, 0, 0, 1, 1, 8'h03)};  // GAP 2
    tbl[8]  = '{5'b01101, pk(0, 0, 0, 0, 1, 1, 8'h03)};  // GAP 3
    tbl[9]  = '{5'b11101, pk(0, 0, 0, 0, 1, 0, 8'h03)};  // GAP 4, req stretches
    tbl[10] = '{5'b10011, pk(0, 0, 0, 0, 1, 0, 8'h00)};  // IDLE, req seen
    tbl[11] = '{5'b11001, pk(1, 0, 1, 0, 0, 1, 8'h01)};
    tbl[12] = '{5'b00110, pk(1, 0, 0, 1, 1, 0, 8'h01)};  // release
    tbl[13] = '{5'b00010, pk(0, 0, 0, 0, 1, 1, 8'h03)};
    tbl[14] = '{5'b00010, pk(0, 0, 0, 0, 1, 1, 8'h03)};
    tbl[15] = '{5'b00010, pk(0, 0, 0, 0, 1, 1, 8'h03)};
    tbl[16] = '{5'b00010, pk(0, 0, 0, 0, 1, 1, 8'h03)};
    tbl[17] = '{5'b00010, pk(0, 0, 0, 0, 1, 1, 8'h00)};  // back to IDLE

    // Reset state, with active CPU inputs applied during reset
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #3;
    push_exp("reset_req1", pk(0, 0, 0, 0, 1, 0, 8'h00));
    check_pop();
    i_cpu_req = 1'b0;
    #1;
    push_exp("reset_req0", pk(0, 0, 0, 0, 1, 1, 8'h00));
    check_pop();
    #19;
    reset = 1'b1;

    // Table-driven CPU read
    for (int i = 0; i < 18; i++) begin
      step($sformatf("cpu_read[%0d]", i), tbl[i].cpu_in[4], tbl[i].cpu_in[3],
           tbl[i].cpu_in[2], tbl[i].cpu_in[1], tbl[i].cpu_in[0],
           1'b1, 1'b1, 1'b1, 1'b0, tbl[i].exp);
    end

    // Simultaneous requests: host wins once synchronized
    step("sim_sync0", 0, 0, 0, 1, 0, 0, 1, 0, 0, pk(0, 0, 0, 0, 1, 1, 8'h00));
    step("sim_sync1", 0, 0, 0, 1, 0, 0, 1, 0, 0, pk(0, 0, 0, 0, 1, 1, 8'h00));
    step("sim_both",  1, 0, 0, 1, 0, 0, 1, 0, 0, pk(0, 0, 0, 0, 1, 0, 8'h00));
    step("sim_host0", 1, 1, 1, 0, 1, 0, 1, 0, 0, pk(0, 1, 1, 0, 0, 0, 8'h12));
    step("sim_host1", 1, 1, 1, 0, 1, 0, 0, 1, 0, pk(0, 1, 0, 1, 0, 0, 8'h1A));
    step("sim_ftup0", 1, 0, 0, 1, 1, 1, 1, 1, 0, pk(0, 1, 1, 1, 0, 0, 8'h1A));
    step("sim_ftup1", 1, 0, 0, 1, 1, 1, 1, 1, 0, pk(0, 1, 1, 1, 0, 0, 8'h1A));
    step("sim_ftup2", 1, 0, 0, 1, 1, 1, 1, 1, 0, pk(0, 1, 1, 1, 0, 0, 8'h1A));
    for (int k = 0; k < 4; k++) begin
      step($sformatf("sim_gap%0d", k), 1, 0, 0, 1, 1, 1, 1, 1, 0,
           pk(0, 0, 0, 0, 1, 0, 8'h1B));
    end
    step("sim_idle", 1, 0, 0, 1, 1, 1, 1, 1, 0, pk(0, 0, 0, 0, 1, 0, 8'h18));
    step("sim_cpu",  1, 0, 0, 0, 1, 1, 1, 1, 0, pk(1, 0, 0, 0, 0, 1, 8'h11));

    // No preemption: host requests while the CPU owns the flash
    step("np_cpu0", 1, 1, 1, 0, 1, 0, 0, 0, 0, pk(1, 0, 1, 1, 0, 1, 8'h11));
    step("np_cpu1", 1, 1, 1, 0, 1, 0, 0, 0, 0, pk(1, 0, 1, 1, 0, 1, 8'h11));
    step("np_cpu2", 1, 1, 1, 0, 1, 0, 0, 0, 0, pk(1, 0, 1, 1, 0, 1, 8'h11));
    step("np_pend", 1, 1, 1, 0, 1, 0, 0, 0, 0, pk(1, 0, 1, 1, 0, 1, 8'h15));
    step("np_rel",  0, 0, 0, 1, 0, 0, 1, 1, 0, pk(1, 0, 0, 0, 1, 0, 8'h15));
    for (int k = 0; k < 4; k++) begin
      step($sformatf("np_gap%0d", k), 0, 0, 0, 1, 0, 0, 1, 1, 0,
           pk(0, 0, 0, 0, 1, 1, 8'h17));
    end
    step("np_idle", 0, 0, 0, 1, 0, 0, 1, 1, 0, pk(0, 0, 0, 0, 1, 1, 8'h14));
    step("np_host", 0, 0, 0, 1, 0, 0, 1, 1, 0, pk(0, 1, 1, 1, 0, 1, 8'h22));
    idle_cycles(10, 1'b1);
    step("np_done", 0, 0, 0, 1, 0, 1, 0, 0, 1, pk(0, 0, 0, 0, 1, 1, 8'h20));

    // Session counter saturation: sessions 3..17
    for (int n = 3; n <= 17; n++) begin
      logic [3:0] sat;
      sat = (n > 15) ? 4'hF : 4'(n);
      idle_cycles(5, 1'b0);
      idle_cycles(10, 1'b1);
      step($sformatf("sat_%0d", n), 0, 0, 0, 1, 0, 1, 0, 0, 1,
           pk(0, 0, 0, 0, 1, 1, {sat, 4'h0}));
    end

    // Reset during HOST with the host selecting the flash
    step("rh_sync0", 0, 0, 0, 1, 0, 0, 1, 1, 0, pk(0, 0, 0, 0, 1, 1, 8'hF0));
    step("rh_sync1", 0, 0, 0, 1, 0, 0, 1, 1, 0, pk(0, 0, 0, 0, 1, 1, 8'hF0));
    step("rh_sync2", 0, 0, 0, 1, 0, 0, 1, 1, 0, pk(0, 0, 0, 0, 1, 1, 8'hF0));
    step("rh_host",  0, 0, 0, 1, 0, 0, 1, 1, 0, pk(0, 1, 1, 1, 0, 1, 8'hF2));
    #2;
    reset = 1'b0;
    #1;
    push_exp("rh_async", pk(0, 0, 0, 0, 1, 1, 8'h00));
    check_pop();
    i_cpu_req = 1'b1;
    #1;
    push_exp("rh_mrdy", pk(0, 0, 0, 0, 1, 0, 8'h00));
    check_pop();
    @(posedge clk);
    #2;
    i_FT_CS = 1'b1;
    #1;
    push_exp("rh_hold", pk(0, 0, 0, 0, 1, 0, 8'h00));
    check_pop();
    #1;
    reset = 1'b1;
    step("rh_restart", 1, 0, 0, 0, 1, 1, 1, 1, 0, pk(1, 0, 0, 0, 0, 1, 8'h01));

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_arbiter.md
SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4: number of clk cycles the flash is held deselected between owners (legal range 1-15).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  internal oscillator clock (88.67 MHz); the only clock.
- reset  in  1  asynchronous, active-low reset.
- i_cpu_req  in  1  6809 flash-window access request (spi_ce from the address decoder), synchronous to clk.
- i_cpu_spi_clk  in  1  SPI clock from the 6809 read controller.
- i_cpu_spi_mosi  in  1  SPI MOSI from the 6809 read controller.
- i_cpu_spi_cs  in  1  SPI chip select from the 6809 read controller, active low.
- i_cpu_ready  in  1  memory-ready from the read controller (1 = data valid).
- i_FT_CS  in  1  FT2232 programming select, active low, asynchronous to clk.
- i_host_spi_clk  in  1  SPI clock from the FT2232 flash writer.
- i_host_spi_mosi  in  1  SPI MOSI from the FT2232 flash writer.
- i_host_spi_cs  in  1  SPI chip select from the FT2232 flash writer, active low.
- o_SPI_CLK  out  1  SPI clock to the flash.
- o_SPI_MOSI  out  1  SPI MOSI to the flash.
- o_SPI_CS  out  1  SPI chip select to the flash, active low.
- o_cpu_grant  out  1  read controller owns the flash.
- o_host_grant  out  1  FT2232 writer owns the flash.
- o_MRDY  out  1  memory-ready to the 6809 (0 = stretch the cycle).
- o_status  out  8  arbiter status byte.

Function
REQ-003 SHALL synchronize i_FT_CS through two clk flops (reset value 1); host_req = inverted synchronized value.
REQ-004 SHALL implement a registered FSM with states IDLE=0, CPU=1, HOST=2, GAP=3.
REQ-005 IDLE: if host_req, go to HOST; else if i_cpu_req, go to CPU; else stay in IDLE. Host wins a simultaneous request.
REQ-006 CPU: go to GAP when i_cpu_req=0 and i_cpu_spi_cs=1 in the same cycle; host_req SHALL NOT preempt CPU and instead sets the host_pending flag.
REQ-007 HOST: go to GAP when host_req=0, regardless of i_host_spi_cs and i_cpu_req; i_cpu_req while in HOST sets the cpu_pending flag.
REQ-008 GAP: load a 4-bit counter with GAP_CYCLES-1 on entry and decrement each cycle; go to IDLE in the cycle after the counter reads 0. GAP therefore lasts exactly GAP_CYCLES cycles.
REQ-009 Output mux selected by the state register only (combinational from registered state):
- CPU: o_SPI_* = i_cpu_spi_*.
- HOST: o_SPI_* = i_host_spi_*.
- IDLE and GAP: o_SPI_CLK=0, o_SPI_MOSI=0, o_SPI_CS=1.
REQ-010 o_cpu_grant = (state==CPU); o_host_grant = (state==HOST). Both SHALL never be 1 together.
REQ-011 o_MRDY, decided per state:
- CPU: o_MRDY = i_cpu_ready.
- Other states with i_cpu_req=1: o_MRDY = 0.
- i_cpu_req=0: o_MRDY = 1.
REQ-012 host_pending clears on entry to HOST; cpu_pending clears on entry to CPU; both are registered.
REQ-013 host_sessions: 4-bit counter incremented on each HOST entry; saturates at 15 (no wrap).
REQ-014 o_status bit map: [1:0]=state, [2]=host_pending, [3]=cpu_pending, [7:4]=host_sessions.
REQ-015 Latency:
- CPU grant is asserted 1 cycle after i_cpu_req is seen in IDLE.
- Host grant is asserted 3 cycles after i_FT_CS falls (2 sync + 1 FSM).

Reset
REQ-016 While reset=0, the block SHALL hold:
- state=IDLE, GAP counter=0, host_pending=0, cpu_pending=0, host_sessions=0, sync flops=1.
- o_SPI_CLK=0, o_SPI_MOSI=0, o_SPI_CS=1, both grants=0, o_status=0x00.
- o_MRDY = ~i_cpu_req.
REQ-017 Reset asserted mid-transfer SHALL force o_SPI_CS=1 immediately (asynchronously); after release, arbitration restarts from IDLE.

Verification
REQ-018 CPU read: i_cpu_req=1 at cycle 0 -> o_cpu_grant=1 at cycle 1; o_MRDY tracks i_cpu_ready; drop req with cs=1 -> GAP for 4 cycles, then IDLE, status[1:0]=0.
REQ-019 Simultaneous: host_req synced and i_cpu_req=1 in the same IDLE cycle -> HOST; o_MRDY=0 throughout HOST; status=0x1A (host_sessions=1, cpu_pending=1, state=HOST).
REQ-020 No preemption: i_FT_CS falls during CPU -> stays CPU, status[2]=1; CPU release -> GAP(4) -> HOST, status[2]=0.
REQ-021 Saturation: 17 host sessions -> status[7:4]=0xF.
REQ-022 Reset during HOST with i_host_spi_cs=0 -> o_SPI_CS=1 and o_host_grant=0 within the same cycle, status=0x00.
